// File: rtl/unidad_fetch_if.sv
// Instruction-memory request/response bus used by the fetch stage.
// master = core side, slave = memory side.
interface unidad_fetch_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_gnt,
        input  imem_rvalid,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_gnt,
        output imem_rvalid,
        output imem_rdata
    );
endinterface

// File: rtl/unidad_fetch.sv
// RV32 fetch stage: PC, single-outstanding imem request, IF/ID register.
// Optional FETCH_STALL_CNT_EN adds a saturating decode-stall counter.
module unidad_fetch #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    unidad_fetch_if.master imem,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    input  logic        id_ready,
    output logic        id_valid,
    output logic [31:0] id_instr,
    output logic [31:0] id_pc
`ifdef FETCH_STALL_CNT_EN
    ,
    output logic [31:0] stall_cnt
`endif
);

    typedef enum logic [1:0] {
        S_REQ,
        S_WAIT,
        S_HOLD,
        S_DROP
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic [31:0] pc;
    logic [31:0] pc_nxt;
    logic [31:0] req_pc;
    logic [31:0] req_pc_nxt;
    logic [31:0] hold_instr;
    logic [31:0] hold_instr_nxt;
    logic [31:0] hold_pc;
    logic [31:0] hold_pc_nxt;
    logic        id_valid_nxt;
    logic [31:0] id_instr_nxt;
    logic [31:0] id_pc_nxt;
    logic        slot_free;
    logic [31:0] redir_pc;
    logic        unused_bits;

    assign redir_pc    = {redirect_pc[31:2], 2'b00};
    assign unused_bits = ^redirect_pc[1:0];
    assign slot_free   = !id_valid || id_ready;

    assign imem.imem_req  = (state == S_REQ) && !rst;
    assign imem.imem_addr = pc;

    always_comb begin
        state_nxt      = state;
        pc_nxt         = pc;
        req_pc_nxt     = req_pc;
        hold_instr_nxt = hold_instr;
        hold_pc_nxt    = hold_pc;
        id_valid_nxt   = id_valid;
        id_instr_nxt   = id_instr;
        id_pc_nxt      = id_pc;

        if (id_valid && id_ready) begin
            id_valid_nxt = 1'b0;
            id_instr_nxt = NOP_INSTR;
        end

        unique case (state)
            S_REQ: begin
                if (imem.imem_gnt) begin
                    req_pc_nxt = pc;
                    state_nxt  = S_WAIT;
                end
            end
            S_WAIT: begin
                if (imem.imem_rvalid) begin
                    if (slot_free) begin
                        id_valid_nxt = 1'b1;
                        id_instr_nxt = imem.imem_rdata;
                        id_pc_nxt    = req_pc;
                        pc_nxt       = req_pc + 32'd4;
                        state_nxt    = S_REQ;
                    end else begin
                        hold_instr_nxt = imem.imem_rdata;
                        hold_pc_nxt    = req_pc;
                        state_nxt      = S_HOLD;
                    end
                end
            end
            S_HOLD: begin
                if (id_ready) begin
                    id_valid_nxt = 1'b1;
                    id_instr_nxt = hold_instr;
                    id_pc_nxt    = hold_pc;
                    pc_nxt       = req_pc + 32'd4;
                    state_nxt    = S_REQ;
                end
            end
            S_DROP: begin
                if (imem.imem_rvalid) begin
                    state_nxt = S_REQ;
                end
            end
            default: state_nxt = S_REQ;
        endcase

        // Redirect wins; an in-flight request must still be drained.
        if (redirect) begin
            pc_nxt         = redir_pc;
            id_valid_nxt   = 1'b0;
            id_instr_nxt   = NOP_INSTR;
            hold_instr_nxt = 32'd0;
            hold_pc_nxt    = 32'd0;
            unique case (state)
                S_REQ:   state_nxt = imem.imem_gnt ? S_DROP : S_REQ;
                S_WAIT:  state_nxt = imem.imem_rvalid ? S_REQ : S_DROP;
                S_HOLD:  state_nxt = S_REQ;
                S_DROP:  state_nxt = S_DROP;
                default: state_nxt = S_REQ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_REQ;
            pc         <= RESET_PC;
            req_pc     <= 32'd0;
            hold_instr <= 32'd0;
            hold_pc    <= 32'd0;
            id_valid   <= 1'b0;
            id_instr   <= NOP_INSTR;
            id_pc      <= 32'd0;
        end else begin
            state      <= state_nxt;
            pc         <= pc_nxt;
            req_pc     <= req_pc_nxt;
            hold_instr <= hold_instr_nxt;
            hold_pc    <= hold_pc_nxt;
            id_valid   <= id_valid_nxt;
            id_instr   <= id_instr_nxt;
            id_pc      <= id_pc_nxt;
        end
    end

`ifdef FETCH_STALL_CNT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt <= 32'd0;
        end else if (id_valid && !id_ready
                     && stall_cnt != 32'hFFFF_FFFF) begin
            stall_cnt <= stall_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_unidad_fetch.sv
// Directed bench for unidad_fetch with a hand-driven imem bus.
// Build with +define+FETCH_STALL_CNT_EN to also cover stall_cnt.
module tb_unidad_fetch;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk;
    logic        rst;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        id_ready;
    logic        id_valid;
    logic [31:0] id_instr;
    logic [31:0] id_pc;
`ifdef FETCH_STALL_CNT_EN
    logic [31:0] stall_cnt;
`endif

    int n_chk;
    int n_err;

    unidad_fetch_if bus();

    unidad_fetch dut (
        .clk         (clk),
        .rst         (rst),
        .imem        (bus),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .id_ready    (id_ready),
        .id_valid    (id_valid),
        .id_instr    (id_instr),
        .id_pc       (id_pc)
`ifdef FETCH_STALL_CNT_EN
        ,
        .stall_cnt   (stall_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h exp %h", tag, got, exp);
        end
    endtask

    // Request seen for two cycles, granted on the second, data one later.
    task automatic fetch(input logic [31:0] a, input logic [31:0] d);
        chk("req", {31'd0, bus.imem_req}, 32'd1);
        chk("addr", bus.imem_addr, a);
        tick();
        chk("req_hold", {31'd0, bus.imem_req}, 32'd1);
        bus.imem_gnt = 1'b1;
        tick();
        bus.imem_gnt = 1'b0;
        chk("wait_noreq", {31'd0, bus.imem_req}, 32'd0);
        bus.imem_rvalid = 1'b1;
        bus.imem_rdata  = d;
        tick();
        bus.imem_rvalid = 1'b0;
        bus.imem_rdata  = 32'h0;
    endtask

    task automatic chk_id(input string tag,
                          input logic v,
                          input logic [31:0] i,
                          input logic [31:0] p);
        chk({tag, "_v"}, {31'd0, id_valid}, {31'd0, v});
        chk({tag, "_i"}, id_instr, i);
        chk({tag, "_pc"}, id_pc, p);
    endtask

    initial begin
        n_chk = 0;
        n_err = 0;
        rst = 1'b1;
        redirect = 1'b0;
        redirect_pc = 32'h0;
        id_ready = 1'b1;
        bus.imem_gnt = 1'b0;
        bus.imem_rvalid = 1'b0;
        bus.imem_rdata = 32'h0;
        tick();
        tick();
        chk("rst_req", {31'd0, bus.imem_req}, 32'd0);
        chk_id("rst", 1'b0, NOP, 32'h0);
        rst = 1'b0;
        #1;

        // basic in-order fetch, id_valid pulses once per 3 cycles
        fetch(32'h0, 32'h0050_0093);
        chk_id("f0", 1'b1, 32'h0050_0093, 32'h0);
        fetch(32'h4, 32'h00A0_0113);
        chk_id("f4", 1'b1, 32'h00A0_0113, 32'h4);
        tick();
        chk_id("f4_gone", 1'b0, NOP, 32'h4);
        fetch(32'h8, 32'h0010_8093);
        chk_id("f8", 1'b1, 32'h0010_8093, 32'h8);

        // decode stall for 5 cycles, response parked in hold
        id_ready = 1'b0;
        bus.imem_gnt = 1'b1;
        tick();
        bus.imem_gnt = 1'b0;
        chk_id("st_a", 1'b1, 32'h0010_8093, 32'h8);
        bus.imem_rvalid = 1'b1;
        bus.imem_rdata = 32'h0020_8113;
        tick();
        bus.imem_rvalid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk_id("st_hold", 1'b1, 32'h0010_8093, 32'h8);
            chk("st_noreq", {31'd0, bus.imem_req}, 32'd0);
            tick();
        end
        id_ready = 1'b1;
        tick();
        chk_id("st_rel", 1'b1, 32'h0020_8113, 32'hC);
        fetch(32'h10, 32'h0031_0193);
        chk_id("f10", 1'b1, 32'h0031_0193, 32'h10);

        // redirect while waiting, response must be dropped
        id_ready = 1'b0;
        bus.imem_gnt = 1'b1;
        tick();
        bus.imem_gnt = 1'b0;
        redirect = 1'b1;
        redirect_pc = 32'h0000_0103;
        tick();
        redirect = 1'b0;
        id_ready = 1'b1;
        chk_id("rw", 1'b0, NOP, 32'h10);
        chk("rw_noreq", {31'd0, bus.imem_req}, 32'd0);
        bus.imem_rvalid = 1'b1;
        bus.imem_rdata = 32'hDEAD_BEEF;
        tick();
        bus.imem_rvalid = 1'b0;
        chk("rw_drop_v", {31'd0, id_valid}, 32'd0);
        fetch(32'h100, 32'h0040_0213);
        chk_id("f100", 1'b1, 32'h0040_0213, 32'h100);

        // redirect coinciding with gnt for addr 8
        redirect = 1'b1;
        redirect_pc = 32'h8;
        tick();
        redirect = 1'b0;
        chk("rg_addr", bus.imem_addr, 32'h8);
        bus.imem_gnt = 1'b1;
        redirect = 1'b1;
        redirect_pc = 32'h200;
        tick();
        bus.imem_gnt = 1'b0;
        redirect = 1'b0;
        chk("rg_noreq", {31'd0, bus.imem_req}, 32'd0);
        bus.imem_rvalid = 1'b1;
        bus.imem_rdata = 32'h0BAD_F00D;
        tick();
        bus.imem_rvalid = 1'b0;
        chk("rg_v", {31'd0, id_valid}, 32'd0);
        chk("rg_i", id_instr, NOP);
        fetch(32'h200, 32'h0050_0293);
        chk_id("f200", 1'b1, 32'h0050_0293, 32'h200);

        // stray rvalid in S_REQ is ignored
        bus.imem_rvalid = 1'b1;
        bus.imem_rdata = 32'h1234_5678;
        tick();
        bus.imem_rvalid = 1'b0;
        chk("stray_v", {31'd0, id_valid}, 32'd0);
        chk("stray_i", id_instr, NOP);
        chk("stray_addr", bus.imem_addr, 32'h204);

        // PC wrap at the top of the address space
        redirect = 1'b1;
        redirect_pc = 32'hFFFF_FFFC;
        tick();
        redirect = 1'b0;
        fetch(32'hFFFF_FFFC, 32'h0060_0313);
        chk_id("fwrap", 1'b1, 32'h0060_0313, 32'hFFFF_FFFC);
        chk("wrap_addr", bus.imem_addr, 32'h0);

        // redirect discards a parked response
        id_ready = 1'b0;
        bus.imem_gnt = 1'b1;
        tick();
        bus.imem_gnt = 1'b0;
        bus.imem_rvalid = 1'b1;
        bus.imem_rdata = 32'hAAAA_AAAA;
        tick();
        bus.imem_rvalid = 1'b0;
        redirect = 1'b1;
        redirect_pc = 32'h40;
        tick();
        redirect = 1'b0;
        id_ready = 1'b1;
        chk("rh_v", {31'd0, id_valid}, 32'd0);
        chk("rh_i", id_instr, NOP);
        fetch(32'h40, 32'h0070_0393);
        chk_id("f40", 1'b1, 32'h0070_0393, 32'h40);

        // reset with a request outstanding, late response ignored
        bus.imem_gnt = 1'b1;
        tick();
        bus.imem_gnt = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        bus.imem_rvalid = 1'b1;
        bus.imem_rdata = 32'h5555_5555;
        tick();
        bus.imem_rvalid = 1'b0;
        chk("mr_v", {31'd0, id_valid}, 32'd0);
        chk("mr_req", {31'd0, bus.imem_req}, 32'd1);
        chk("mr_addr", bus.imem_addr, 32'h0);

`ifdef FETCH_STALL_CNT_EN
        fetch(32'h0, 32'h0050_0093);
        chk("sc_zero", stall_cnt, 32'd0);
        id_ready = 1'b0;
        repeat (7) tick();
        chk("sc_7", stall_cnt, 32'd7);
        chk("sc_instr", id_instr, 32'h0050_0093);
        rst = 1'b1;
        tick();
        chk("sc_rst", stall_cnt, 32'd0);
        rst = 1'b0;
        id_ready = 1'b1;
`endif

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
